node_info_ctrl: RTL
===================

// Module: node_info_ctrl
// PURPOSE
//  Parametrised per-node state keeper for the EER-RL clustering datapath.
//  Latches network parameters from the first accepted heartbeat (HB) packet.
//  Runs the node's role FSM (unclustered/member/cluster-head/recluster) and tracks the low-energy condition with hysteresis.
//  Holds the node's Q-value and TDMA timeslot. Sits between the packet filter (fPktType/en_MNI) and the routing/Q-learning logic.
// PARAMETERS
//  WORD_W       16       width of all energy/ID/hop/Q/timeslot fields
//  PKT_W        3        packet-type code width
//  NODE_ID      16'h000C this node's ID (WORD_W bits)
//  E_HYST       16'd8    low_E release margin above e_threshold
//  LOCK_TIMEOUT 1024     cycles before an HB lock self-releases; 0 = never
// PORTS
//  clk           in   1       clock, rising edge
//  nrst          in   1       async active-low reset
//  en_MNI        in   1       packet fields valid this cycle
//  fPktType      in   PKT_W   decoded packet type
//  e_max,e_min   in   WORD_W  network energy bounds (HB)
//  e_threshold   in   WORD_W  low-energy threshold (HB)
//  hops          in   WORD_W  hop count carried by HB
//  ch_ID         in   WORD_W  cluster-head ID carried by CHE
//  timeslot      in   WORD_W  slot carried by TS packet
//  energy        in   WORD_W  current residual energy (sampled every cycle)
//  q_valid,q_in  in   1,WORD_W  new Q-value from the Q-compute unit
//  myNodeID      out  WORD_W  = NODE_ID, constant
//  hopsFromSink  out  WORD_W  latched hops
//  myCHID        out  WORD_W  joined cluster head ID
//  myTimeslot    out  WORD_W  latched slot
//  myQValue      out  WORD_W  latched Q-value
//  eMin,eMax,eThr out WORD_W  latched HB energy params
//  role          out  2       FSM state code
//  is_CH         out  1       role==CH
//  low_E         out  1       low-energy flag
//  hb_lock       out  1       HB acceptance lock
//  sos_req       out  1       1-cycle pulse: CH entered low energy
// BEHAVIOUR
//  - Reset: every register/output 0; role=UNCL; myNodeID is constant.
//  - All updates are registered, 1-cycle latency from the qualifying input cycle. Packet fields count only when en_MNI=1.
//  - HB accept (en & HB & !hb_lock): hopsFromSink<=hops, eMin/eMax/eThr<=inputs; hb_lock<=1; lock_cnt<=0.
//  - hb_lock release priority: DATA pkt (en) > entry to RECL > lock_cnt==LOCK_TIMEOUT-1.
//      lock_cnt increments while locked and is cleared on release.
//      An HB arriving in the release cycle is ignored; a later HB is accepted.
//  - Role FSM (codes UNCL=0 MEMBER=1 CH=2 RECL=3):
//      UNCL  -CHE,ch_ID==NODE_ID->  CH, myCHID<=NODE_ID
//      UNCL  -CHE,other->  MEMBER, myCHID<=ch_ID  (first CHE wins)
//      MEMBER/CH  -CHE->  no change
//      MEMBER/CH  -SOS->  RECL
//      CH  -low_E rising edge->  RECL
//      RECL  -HB->  UNCL: myCHID,myTimeslot cleared; HB params captured same cycle (lock is already free).
//  - TS pkt: myTimeslot<=timeslot only when role==MEMBER; ignored otherwise.
//  - low_E: set when energy<eThr; cleared when energy >= eThr+E_HYST, sum computed WORD_W+1 bits (no wrap); otherwise holds.
//  - sos_req=1 for exactly one cycle on low_E 0->1 while role==CH. No re-pulse until low_E clears and sets again.
//  - myQValue<=q_in when q_valid; holds otherwise.
//  - Unknown pkt codes: no state change except lock_cnt/low_E.
// STRUCTURE
//  - Shared package eer_pkg: PKT_HB=0, PKT_CHE=1, PKT_TS=4, PKT_DATA=5, PKT_SOS=6; role_t enum {UNCL,MEMBER,CH,RECL}.
//  - One sub-module: energy_hyst_cmp (low_E + rising-edge detect).
//  - Remaining logic is flat: FSM, param registers, lock counter.
// TESTING
//  1 HB(hops=3,eThr=100) then HB(hops=7) -> hopsFromSink=3, eThr=100, hb_lock=1.
//  2 Lock held, DATA pkt, then HB(hops=5) -> lock drops next cycle, hopsFromSink=5.
//  3 LOCK_TIMEOUT=4, HB, idle -> hb_lock clears exactly 4 cycles after set.
//      Repeat with HB in the release cycle -> that HB is ignored.
//  4 CHE(ch_ID=0x000C) -> role=2, is_CH=1. Then energy 99 with eThr=100
//      -> low_E=1, sos_req 1 cycle, role=3. HB -> role=0, myCHID=0.
//  5 CHE(0x0003) then CHE(0x0009), TS(slot=6) -> role=1, myCHID=3, myTimeslot=6.
//      Then SOS -> role=3; TS(slot=2) ignored.
//  6 eThr=0xFFFC, E_HYST=8, energy 0xFFFB then 0xFFFF
//      -> low_E stays 1 (no wrap). Assert nrst mid-lock -> all outputs 0 immediately.

Source files
------------

// File: rtl/eer_pkg.sv
// Shared definitions for the EER-RL node datapath: packet type codes and node roles.
package eer_pkg;

    localparam int PKT_HB   = 0;
    localparam int PKT_CHE  = 1;
    localparam int PKT_TS   = 4;
    localparam int PKT_DATA = 5;
    localparam int PKT_SOS  = 6;

    typedef enum logic [1:0] {
        UNCL   = 2'd0,
        MEMBER = 2'd1,
        CH     = 2'd2,
        RECL   = 2'd3
    } role_t;

endpackage

// File: rtl/node_info_ctrl_if.sv
// Packet-filter to node-state bus: decoded packet fields, residual energy and Q-value update.
interface node_info_ctrl_if #(
    parameter int WORD_W = 16,
    parameter int PKT_W  = 3
);
    logic              en_MNI;
    logic [PKT_W-1:0]  fPktType;
    logic [WORD_W-1:0] e_max;
    logic [WORD_W-1:0] e_min;
    logic [WORD_W-1:0] e_threshold;
    logic [WORD_W-1:0] hops;
    logic [WORD_W-1:0] ch_ID;
    logic [WORD_W-1:0] timeslot;
    logic [WORD_W-1:0] energy;
    logic              q_valid;
    logic [WORD_W-1:0] q_in;

    modport master (
        output en_MNI, fPktType, e_max, e_min, e_threshold, hops,
               ch_ID, timeslot, energy, q_valid, q_in
    );

    modport slave (
        input  en_MNI, fPktType, e_max, e_min, e_threshold, hops,
               ch_ID, timeslot, energy, q_valid, q_in
    );
endinterface

// File: rtl/energy_hyst_cmp.sv
// Low-energy flag with hysteresis above the threshold, plus a rising-edge strobe
// that lines up with the cycle the flag is registered.
module energy_hyst_cmp #(
    parameter int                WORD_W = 16,
    parameter logic [WORD_W-1:0] E_HYST = 16'd8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [WORD_W-1:0] energy,
    input  logic [WORD_W-1:0] e_thr,
    output logic              low_e,
    output logic              low_e_rise
);

    logic              low_e_nxt;
    logic [WORD_W:0]   release_lvl;

    // One extra bit so a threshold near full scale cannot wrap the release level.
    assign release_lvl = {1'b0, e_thr} + {1'b0, E_HYST};

    always_comb begin
        low_e_nxt = low_e;
        if (energy < e_thr)
            low_e_nxt = 1'b1;
        else if ({1'b0, energy} >= release_lvl)
            low_e_nxt = 1'b0;
    end

    assign low_e_rise = low_e_nxt & ~low_e;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            low_e <= 1'b0;
        else
            low_e <= low_e_nxt;
    end

endmodule

// File: rtl/node_info_ctrl.sv
// Per-node state keeper: HB parameter capture with lock, role FSM, timeslot,
// Q-value and low-energy SOS request.
module node_info_ctrl
    import eer_pkg::*;
#(
    parameter int                WORD_W       = 16,
    parameter int                PKT_W        = 3,
    parameter logic [WORD_W-1:0] NODE_ID      = 16'h000C,
    parameter logic [WORD_W-1:0] E_HYST       = 16'd8,
    parameter int                LOCK_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              nrst,
    node_info_ctrl_if.slave   bus,
    output logic [WORD_W-1:0] myNodeID,
    output logic [WORD_W-1:0] hopsFromSink,
    output logic [WORD_W-1:0] myCHID,
    output logic [WORD_W-1:0] myTimeslot,
    output logic [WORD_W-1:0] myQValue,
    output logic [WORD_W-1:0] eMin,
    output logic [WORD_W-1:0] eMax,
    output logic [WORD_W-1:0] eThr,
    output logic [1:0]        role,
    output logic              is_CH,
    output logic              low_E,
    output logic              hb_lock,
    output logic              sos_req
);

    localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    role_t            role_q, role_d;
    logic [CNT_W-1:0] lock_cnt;
    logic             pkt_hb, pkt_che, pkt_ts, pkt_data, pkt_sos;
    logic             hb_accept, hb_release, enter_recl, timeout_hit, low_e_rise;

    assign pkt_hb   = bus.en_MNI && (bus.fPktType == PKT_W'(PKT_HB));
    assign pkt_che  = bus.en_MNI && (bus.fPktType == PKT_W'(PKT_CHE));
    assign pkt_ts   = bus.en_MNI && (bus.fPktType == PKT_W'(PKT_TS));
    assign pkt_data = bus.en_MNI && (bus.fPktType == PKT_W'(PKT_DATA));
    assign pkt_sos  = bus.en_MNI && (bus.fPktType == PKT_W'(PKT_SOS));

    energy_hyst_cmp #(.WORD_W(WORD_W), .E_HYST(E_HYST)) u_energy_cmp (
        .clk        (clk),
        .nrst       (nrst),
        .energy     (bus.energy),
        .e_thr      (eThr),
        .low_e      (low_E),
        .low_e_rise (low_e_rise)
    );

    always_comb begin
        role_d = role_q;
        case (role_q)
            UNCL:    if (pkt_che) role_d = (bus.ch_ID == NODE_ID) ? CH : MEMBER;
            MEMBER:  if (pkt_sos) role_d = RECL;
            CH:      if (pkt_sos || low_e_rise) role_d = RECL;
            RECL:    if (pkt_hb) role_d = UNCL;
            default: role_d = UNCL;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            role_q <= UNCL;
        else
            role_q <= role_d;
    end

    assign enter_recl  = (role_q != RECL) && (role_d == RECL);
    assign timeout_hit = (LOCK_TIMEOUT != 0) && (lock_cnt == CNT_W'(LOCK_TIMEOUT - 1));
    assign hb_release  = hb_lock && (pkt_data || enter_recl || timeout_hit);
    assign hb_accept   = pkt_hb && !hb_lock;

    // A release always wins; an HB seen while still locked is simply dropped.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hb_lock  <= 1'b0;
            lock_cnt <= '0;
        end else if (hb_release) begin
            hb_lock  <= 1'b0;
            lock_cnt <= '0;
        end else if (hb_accept) begin
            hb_lock  <= 1'b1;
            lock_cnt <= '0;
        end else if (hb_lock) begin
            lock_cnt <= lock_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hopsFromSink <= '0;
            eMin         <= '0;
            eMax         <= '0;
            eThr         <= '0;
            myCHID       <= '0;
            myTimeslot   <= '0;
            myQValue     <= '0;
            sos_req      <= 1'b0;
        end else begin
            if (hb_accept) begin
                hopsFromSink <= bus.hops;
                eMin         <= bus.e_min;
                eMax         <= bus.e_max;
                eThr         <= bus.e_threshold;
            end
            if (role_q == UNCL && pkt_che)
                myCHID <= bus.ch_ID;
            if (role_q == MEMBER && pkt_ts)
                myTimeslot <= bus.timeslot;
            if (role_q == RECL && pkt_hb) begin
                myCHID     <= '0;
                myTimeslot <= '0;
            end
            if (bus.q_valid)
                myQValue <= bus.q_in;
            sos_req <= low_e_rise && (role_q == CH);
        end
    end

    assign myNodeID = NODE_ID;
    assign role     = role_q;
    assign is_CH    = (role_q == CH);

endmodule
